alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 nRst  input  1  asynchronous active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  requester n's operation is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32 each  signed operands.
REQ-007 req0_op / req1_op  input  6 each  ALU opcode, using the codebase control-unit opcode encoding.
REQ-008 alu_a, alu_b  output  32 each; alu_op  output  6: drive the shared ALU.
REQ-009 alu_result  input  32; alu_negative, alu_zero  input  1 each: combinational ALU return.
REQ-010 rsp_valid  output  1; rsp_id  output  1; rsp_result  output  32; rsp_negative, rsp_zero  output  1 each.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 ops_done  output  16  count of completed response handshakes.

Function
REQ-014 FSM states: IDLE, ISSUE, RESP; there are no other states.
REQ-015 IDLE: if any reqN_valid is high, assert ready for the granted requester only, latch its a/b/op and id, and go to ISSUE; otherwise stay in IDLE.
REQ-016 reqN_ready is combinational from state and valids, and is never high outside IDLE; both readies are never high together.
REQ-017 ISSUE lasts exactly one cycle: alu_a/alu_b/alu_op carry the latched values; on the clock edge, capture alu_result/negative/zero into the rsp_* registers and go to RESP.
REQ-018 alu_a/alu_b/alu_op always show the latched registers, which hold their value outside ISSUE.
REQ-019 RESP: rsp_valid is high, and all rsp_* values are stable until rsp_valid and rsp_ready are both high; on that edge, go to IDLE and increment ops_done.
REQ-020 Latency: rsp_valid rises 2 cycles after the accept edge; minimum spacing between accepts is 3 cycles.
REQ-021 A rsp_ready held high before RESP completes the handshake in the first RESP cycle.
REQ-022 ops_done wraps from 0xFFFF to 0x0000.
REQ-023 Requesters hold valid and operands until ready; a valid that drops before acceptance is never issued.
REQ-024 Opcodes are passed through unchecked; an unsupported op completes normally with whatever the ALU returns.

Reset
REQ-025 Asserting nRst at any time, including mid-ISSUE or mid-RESP, immediately forces IDLE and discards any pending operation.
REQ-026 Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_negative=0, rsp_zero=0, alu_a=0, alu_b=0, alu_op=0, ops_done=0, busy=0, last_grant=1.

Configuration
REQ-027 Macro ALU_ARB_RR_EN defined: round-robin arbitration; when both requesters are valid, grant the one not in last_grant; last_grant updates on each accept.
REQ-028 Macro ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins; last_grant is absent or unused.
REQ-029 A single requester that is valid alone is granted in both configurations.

Verification
REQ-030 Req0 ADD a=5, b=-7, rsp_ready=1 -> rsp_valid 2 cycles after accept; rsp_id=0, result=0xFFFFFFFE, negative=1, zero=0; ops_done=1.
REQ-031 Both requesters valid continuously, RR_EN defined -> grants alternate 0,1,0,1 over 4 operations; RR_EN undefined -> grants 0,0,0,0.
REQ-032 Req1 SUB 9-9 with rsp_ready=0 for 5 cycles -> rsp_valid held with result=0, zero=1, stable for the whole stall; no readies asserted; handshake on the 6th cycle -> IDLE.
REQ-033 nRst pulsed during ISSUE of an SLL op -> next cycle IDLE, rsp_valid=0, ops_done unchanged at 0; the next request completes normally.
REQ-034 Preload ops_done=0xFFFF via 65535 operations (or force) and then 1 more -> ops_done=0x0000.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester front end for one shared combinational ALU.
//            Grants one operation at a time: IDLE -> ISSUE -> RESP.
//            Optional macro ALU_ARB_RR_EN selects round-robin arbitration;
//            without it, requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              nRst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [5:0]        req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [5:0]        req1_op,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_negative,
    input  logic              alu_zero,

    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_negative,
    output logic              rsp_zero,
    input  logic              rsp_ready,

    output logic              busy,
    output logic [15:0]       ops_done
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_resp  = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [5:0]        r_op;
    logic              r_id;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_rsp_negative;
    logic              r_rsp_zero;
    logic [15:0]       r_ops_done;

    logic              w_idle;
    logic              w_accept;
    logic              w_grant1;

    assign w_idle   = (r_state == c_idle);
    assign w_accept = w_idle && (req0_valid || req1_valid);

`ifdef ALU_ARB_RR_EN
    logic              r_last_grant;

    // On contention the requester that did not win last time goes next.
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
`else
    assign w_grant1 = req1_valid && !req0_valid;
`endif

    assign req0_ready = w_accept && !w_grant1;
    assign req1_ready = w_accept &&  w_grant1;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state        <= c_idle;
            r_a            <= '0;
            r_b            <= '0;
            r_op           <= '0;
            r_id           <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_negative <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_ops_done     <= '0;
`ifdef ALU_ARB_RR_EN
            r_last_grant   <= 1'b1;
`endif
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_accept) begin
                        r_a     <= w_grant1 ? req1_a  : req0_a;
                        r_b     <= w_grant1 ? req1_b  : req0_b;
                        r_op    <= w_grant1 ? req1_op : req0_op;
                        r_id    <= w_grant1;
                        r_state <= c_issue;
`ifdef ALU_ARB_RR_EN
                        r_last_grant <= w_grant1;
`endif
                    end
                end
                c_issue: begin
                    // The ALU sees the latched operands for exactly this cycle.
                    r_rsp_valid    <= 1'b1;
                    r_rsp_id       <= r_id;
                    r_rsp_result   <= alu_result;
                    r_rsp_negative <= alu_negative;
                    r_rsp_zero     <= alu_zero;
                    r_state        <= c_resp;
                end
                c_resp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_done  <= r_ops_done + 16'd1;
                        r_state     <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign alu_op       = r_op;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_negative = r_rsp_negative;
    assign rsp_zero     = r_rsp_zero;
    assign busy         = !w_idle;
    assign ops_done     = r_ops_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter with a behavioural ALU stub
//            and a transaction-level model of arbitration and responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam logic [5:0] OP_SLL = 6'h00;
    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_SLT = 6'h2a;

    logic        clk = 1'b0;
    logic        nRst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [5:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [5:0]  alu_op;
    logic        alu_negative, alu_zero;
    logic        rsp_valid, rsp_id, rsp_negative, rsp_zero, rsp_ready;
    logic [31:0] rsp_result;
    logic        busy;
    logic [15:0] ops_done;

    int          checks = 0;
    int          errors = 0;
    logic        m_last;
    logic [15:0] m_ops;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .nRst(nRst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_negative(rsp_negative), .rsp_zero(rsp_zero), .rsp_ready(rsp_ready),
        .busy(busy), .ops_done(ops_done)
    );

    // Behavioural shared ALU; unknown opcodes return an arbitrary mix.
    function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[4:0];
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return {31'd0, ($signed(a) < $signed(b))};
            default: return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    assign alu_result   = alu_fn(alu_op, alu_a, alu_b);
    assign alu_negative = alu_result[31];
    assign alu_zero     = (alu_result == 32'd0);

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [7];
        ops = '{OP_SLL, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT};
        if ($urandom_range(0, 7) == 0) return 6'($urandom_range(0, 63));
        return ops[$urandom_range(0, 6)];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        nRst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;
        m_last = 1'b1;
        m_ops = 16'd0;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_negative, rsp_zero} !== 36'd0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b id=%b res=%h n=%b z=%b, want all 0", rsp_valid, rsp_id, rsp_result, rsp_negative, rsp_zero);
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== 70'd0) begin
            errors++;
            $display("FAIL reset_alu: got a=%h b=%h op=%h, want 0", alu_a, alu_b, alu_op);
        end
        checks++;
        if (ops_done !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt_busy: got ops_done=%h busy=%b, want 0 0", ops_done, busy);
        end
        @(negedge clk);
        nRst = 1'b1;
        m_last = 1'b1;
        m_ops = 16'd0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got r0=%b r1=%b busy=%b, want 0 0 0", req0_ready, req1_ready, busy);
        end
    endtask

    task automatic test_add();
        @(negedge clk);
        req0_a = 32'd5; req0_b = -32'sd7; req0_op = OP_ADD; req0_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL add_accept: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid} !== 2'b10 || alu_a !== 32'd5 || alu_b !== 32'hFFFF_FFF9 || alu_op !== OP_ADD) begin
            errors++;
            $display("FAIL add_issue: got busy=%b v=%b a=%h b=%h op=%h, want 1 0 5 fffffff9 20", busy, rsp_valid, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_negative, rsp_zero} !== {1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_resp: got v=%b id=%b res=%h n=%b z=%b, want 1 0 fffffffe 1 0", rsp_valid, rsp_id, rsp_result, rsp_negative, rsp_zero);
        end
        @(negedge clk);
        m_ops = m_ops + 16'd1;
        checks++;
        if ({busy, rsp_valid} !== 2'b00 || ops_done !== 16'd1) begin
            errors++;
            $display("FAIL add_done: got busy=%b v=%b ops_done=%0d, want 0 0 1", busy, rsp_valid, ops_done);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        req1_a = 32'd9; req1_b = 32'd9; req1_op = OP_SUB; req1_valid = 1'b1; rsp_ready = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL stall_accept: got r0=%b r1=%b, want 0 1", req0_ready, req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        req0_a = $urandom; req0_b = $urandom; req0_op = OP_ADD; req0_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                rsp_ready = 1'b1;
                req0_valid = 1'b0;
            end
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_negative, rsp_zero, req0_ready, req1_ready} !== {1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b id=%b res=%h n=%b z=%b r0=%b r1=%b, want 1 1 0 0 1 0 0", i, rsp_valid, rsp_id, rsp_result, rsp_negative, rsp_zero, req0_ready, req1_ready);
            end
            @(negedge clk);
        end
        m_ops = m_ops + 16'd1;
        checks++;
        if ({busy, rsp_valid} !== 2'b00 || ops_done !== m_ops) begin
            errors++;
            $display("FAIL stall_done: got busy=%b v=%b ops_done=%0d, want 0 0 %0d", busy, rsp_valid, ops_done, m_ops);
        end
        // The requester that withdrew must never be issued.
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_withdrawn: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_arbitration();
        int grants[$];
        int want[4];
`ifdef ALU_ARB_RR_EN
        want = '{0, 1, 0, 1};
`else
        want = '{0, 0, 0, 0};
`endif
        do_reset();
        req0_a = $urandom; req0_b = $urandom; req0_op = OP_XOR; req0_valid = 1'b1;
        req1_a = $urandom; req1_b = $urandom; req1_op = OP_OR;  req1_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && grants.size() < 4; cyc++) begin
            #1;
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (grants.size() != 4) begin
            errors++;
            $display("FAIL arb_count: got %0d grants, want 4", grants.size());
        end
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            checks++;
            if (grants[i] != want[i]) begin
                errors++;
                $display("FAIL arb_grant[%0d]: got %0d, want %0d", i, grants[i], want[i]);
            end
        end
        repeat (3) @(negedge clk);
        m_ops = m_ops + 16'(grants.size());
        checks++;
        if (ops_done !== m_ops || busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_done: got ops_done=%0d busy=%b, want %0d 0", ops_done, busy, m_ops);
        end
        m_last = (grants.size() > 0) ? grants[grants.size()-1][0] : m_last;
    endtask

    task automatic test_random();
        logic        pend, e_r0, e_r1, e_g1, e_rv;
        int          age;
        logic [35:0] exp_rsp;
        logic        acc0, acc1;
        pend = 1'b0; age = 0; exp_rsp = '0;
        @(negedge clk);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            #1;
            if (!req0_valid) begin
                e_g1 = req1_valid;
            end else if (!req1_valid) begin
                e_g1 = 1'b0;
            end else begin
`ifdef ALU_ARB_RR_EN
                e_g1 = (m_last == 1'b0);
`else
                e_g1 = 1'b0;
`endif
            end
            e_r0 = !pend && req0_valid && !e_g1;
            e_r1 = !pend && req1_valid && e_g1;
            e_rv = pend && (age >= 2);
            checks++;
            if ({req0_ready, req1_ready} !== {e_r0, e_r1}) begin
                errors++;
                $display("FAIL rnd_ready@%0d: got %b%b, want %b%b", cyc, req0_ready, req1_ready, e_r0, e_r1);
            end
            checks++;
            if (rsp_valid !== e_rv || busy !== pend) begin
                errors++;
                $display("FAIL rnd_state@%0d: got v=%b busy=%b, want %b %b", cyc, rsp_valid, busy, e_rv, pend);
            end
            if (e_rv) begin
                checks++;
                if ({rsp_id, rsp_result, rsp_negative, rsp_zero} !== exp_rsp) begin
                    errors++;
                    $display("FAIL rnd_rsp@%0d: got %h, want %h", cyc, {rsp_id, rsp_result, rsp_negative, rsp_zero}, exp_rsp);
                end
            end
            checks++;
            if (ops_done !== m_ops) begin
                errors++;
                $display("FAIL rnd_ops@%0d: got %0d, want %0d", cyc, ops_done, m_ops);
            end
            acc0 = e_r0; acc1 = e_r1;
            if (e_r0 || e_r1) begin
                logic [31:0] r;
                r = e_r1 ? alu_fn(req1_op, req1_a, req1_b) : alu_fn(req0_op, req0_a, req0_b);
                exp_rsp = {e_r1, r, r[31], (r == 32'd0)};
                pend = 1'b1; age = 1; m_last = e_r1;
            end else if (pend) begin
                if (e_rv && rsp_ready) begin
                    pend = 1'b0;
                    m_ops = m_ops + 16'd1;
                end else begin
                    age++;
                end
            end
            @(negedge clk);
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 1) == 1) begin
                req0_a = $urandom; req0_b = $urandom; req0_op = rand_op(); req0_valid = 1'b1;
            end
            if (!req1_valid && $urandom_range(0, 1) == 1) begin
                req1_a = $urandom; req1_b = $urandom; req1_op = rand_op(); req1_valid = 1'b1;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        req0_a = 32'd1; req0_b = 32'd4; req0_op = OP_SLL; req0_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_issue: got busy=%b, want 1", busy);
        end
        nRst = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid} !== 2'b00 || ops_done !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_async: got busy=%b v=%b ops_done=%0d, want 0 0 0", busy, rsp_valid, ops_done);
        end
        @(negedge clk);
        nRst = 1'b1;
        m_last = 1'b1; m_ops = 16'd0;
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid} !== 2'b00 || ops_done !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_after: got busy=%b v=%b ops_done=%0d, want 0 0 0", busy, rsp_valid, ops_done);
        end
        req1_a = 32'd100; req1_b = 32'd23; req1_op = OP_SUB; req1_valid = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'd77}) begin
            errors++;
            $display("FAIL rstmid_next: got v=%b id=%b res=%0d, want 1 1 77", rsp_valid, rsp_id, rsp_result);
        end
        @(negedge clk);
        m_ops = 16'd1;
        checks++;
        if (ops_done !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_count: got %0d, want 1", ops_done);
        end
        // Reset while a response is stalled in RESP.
        rsp_ready = 1'b0;
        req0_a = 32'd3; req0_b = 32'd3; req0_op = OP_AND; req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        nRst = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid, rsp_result} !== 34'd0 || ops_done !== 16'd0) begin
            errors++;
            $display("FAIL rstmid_resp: got busy=%b v=%b res=%h ops_done=%0d, want 0 0 0 0", busy, rsp_valid, rsp_result, ops_done);
        end
        @(negedge clk);
        nRst = 1'b1;
        m_last = 1'b1; m_ops = 16'd0;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.r_ops_done = 16'hFFFF;
        #1;
        release dut.r_ops_done;
        #1;
        checks++;
        if (ops_done !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h, want ffff", ops_done);
        end
        @(negedge clk);
        req0_a = $urandom; req0_b = $urandom; req0_op = OP_OR; req0_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ops_done !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_rollover: got ops_done=%h busy=%b, want 0000 0", ops_done, busy);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_stall();
        test_arbitration();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
